// File: rtl/ws281x_chain_drv_if.sv
// ----------------------------------------------------------------------------
// ws281x_chain_drv_if
// Bus bundle for the WS281x chain driver: frame-buffer write port, frame
// control inputs and status/serial outputs.
//   wr_en_i   : write one colour entry this cycle
//   wr_addr_i : LED index to write (width $clog2(NumLeds), minimum 1)
//   wr_data_i : colour {G[7:0], R[7:0], B[7:0]}
//   go_i      : start-frame pulse
//   auto_i    : auto-refresh mode
//   busy_o    : frame or latch in progress
//   done_o    : one-cycle pulse on the last latch cycle
//   dout_o    : serial line to the first LED
// Modports: master drives the controls, slave is the driver itself.
// ----------------------------------------------------------------------------
interface ws281x_chain_drv_if #(
  parameter int NumLeds = 8
) ();
  localparam int AddrW = (NumLeds > 1) ? $clog2(NumLeds) : 1;

  logic             wr_en_i;
  logic [AddrW-1:0] wr_addr_i;
  logic [23:0]      wr_data_i;
  logic             go_i;
  logic             auto_i;
  logic             busy_o;
  logic             done_o;
  logic             dout_o;

  modport master (
    output wr_en_i, wr_addr_i, wr_data_i, go_i, auto_i,
    input  busy_o, done_o, dout_o
  );

  modport slave (
    input  wr_en_i, wr_addr_i, wr_data_i, go_i, auto_i,
    output busy_o, done_o, dout_o
  );
endinterface

// File: rtl/ws281x_chain_drv.sv
// ----------------------------------------------------------------------------
// ws281x_chain_drv
// Drives a daisy chain of WS281x LEDs from an internal NumLeds x 24-bit frame
// buffer. Each frame sends every LED's GRB word MSB-first, then holds the
// line low for LatchCycles so the LEDs latch.
// Ports:
//   clk_i : clock, rising edge
//   rst_i : synchronous active-high reset
//   bus   : ws281x_chain_drv_if.slave (write port, go/auto, busy/done/dout)
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for go_i; line low, led_idx held at 0
// LOAD  | one cycle; copy buffer[led_idx] into the shift register
// SEND  | serialise 24 bits, BitCycles per bit
// LATCH | line low for LatchCycles; done_o on the last cycle
// ----------------------------------------------------------------------------
module ws281x_chain_drv #(
  parameter int NumLeds     = 8,
  parameter int BitCycles   = 30,
  parameter int T0HCycles   = 10,
  parameter int T1HCycles   = 20,
  parameter int LatchCycles = 2000,
  parameter int InvertOut   = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  ws281x_chain_drv_if.slave       bus
);

  localparam int AddrW  = (NumLeds > 1) ? $clog2(NumLeds) : 1;
  localparam int CntMax = (LatchCycles > BitCycles) ? LatchCycles : BitCycles;
  localparam int CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

  localparam logic [CntW-1:0]  BitLast    = CntW'(BitCycles - 1);
  localparam logic [CntW-1:0]  LatchLast  = CntW'(LatchCycles - 1);
  localparam logic [CntW-1:0]  T0High     = CntW'(T0HCycles);
  localparam logic [CntW-1:0]  T1High     = CntW'(T1HCycles);
  localparam logic [AddrW-1:0] LastLed    = AddrW'(NumLeds - 1);
  localparam logic [AddrW:0]   NumLedsExt = (AddrW + 1)'(NumLeds);
  localparam logic             InvBit     = (InvertOut != 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_LATCH
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [23:0]      r_fbuf [NumLeds];
  logic [23:0]      r_shift;
  logic [4:0]       r_bit_cnt;
  logic [CntW-1:0]  r_cnt;
  logic [AddrW-1:0] r_led_idx;
  logic             r_pending;
  logic             r_dout;

  logic             w_line;
  logic             w_busy;
  logic             w_done;
  logic             w_bit_end;
  logic             w_wr_ok;

  assign w_bit_end = (r_cnt == BitLast);
  // Indices past the end of the chain are dropped, not aliased.
  assign w_wr_ok   = bus.wr_en_i && ({1'b0, bus.wr_addr_i} < NumLedsExt);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_line      = 1'b0;
    w_busy      = (r_state != S_IDLE);
    w_done      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.go_i) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        w_state_nxt = S_SEND;
      end
      S_SEND: begin
        w_line = r_shift[23] ? (r_cnt < T1High) : (r_cnt < T0High);
        if (w_bit_end && (r_bit_cnt == 5'd0)) begin
          w_state_nxt = (r_led_idx == LastLed) ? S_LATCH : S_LOAD;
        end
      end
      S_LATCH: begin
        if (r_cnt == LatchLast) begin
          w_done = 1'b1;
          // A go_i landing on this very cycle is honoured as if already pending.
          w_state_nxt = (r_pending || bus.go_i || bus.auto_i) ? S_LOAD : S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumLeds; i++) r_fbuf[i] <= 24'h000000;
      r_shift   <= 24'h000000;
      r_bit_cnt <= 5'd0;
      r_cnt     <= '0;
      r_led_idx <= '0;
      r_pending <= 1'b0;
      r_dout    <= InvBit;
    end else begin
      r_dout <= w_line ^ InvBit;

      if (w_wr_ok) r_fbuf[bus.wr_addr_i] <= bus.wr_data_i;

      if ((r_state == S_LATCH) && (w_state_nxt == S_LOAD)) begin
        r_pending <= 1'b0;
      end else if (bus.go_i && (r_state != S_IDLE)) begin
        r_pending <= 1'b1;
      end

      unique case (r_state)
        S_IDLE: begin
          r_led_idx <= '0;
          r_cnt     <= '0;
        end
        S_LOAD: begin
          // Reads the pre-edge buffer, so a same-cycle write is seen next frame.
          r_shift   <= r_fbuf[r_led_idx];
          r_bit_cnt <= 5'd23;
          r_cnt     <= '0;
        end
        S_SEND: begin
          if (w_bit_end) begin
            r_cnt     <= '0;
            r_shift   <= {r_shift[22:0], 1'b0};
            r_bit_cnt <= r_bit_cnt - 5'd1;
            if ((r_bit_cnt == 5'd0) && (w_state_nxt == S_LOAD)) begin
              r_led_idx <= r_led_idx + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_LATCH: begin
          if (r_cnt == LatchLast) begin
            r_cnt     <= '0;
            r_led_idx <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

  assign bus.busy_o = w_busy;
  assign bus.done_o = w_done;
  assign bus.dout_o = r_dout;

endmodule

// File: tb/tb_ws281x_chain_drv.sv
// ----------------------------------------------------------------------------
// tb_ws281x_chain_drv
// Two drivers (InvertOut=1 and InvertOut=0) share one stimulus stream. The
// expected line level is derived from the LED timing rules: each LED takes one
// load cycle followed by 24 bit slots, and the frame ends with a low latch.
// ----------------------------------------------------------------------------
module tb_ws281x_chain_drv;
  localparam int N       = 3;
  localparam int BC      = 30;
  localparam int T0      = 10;
  localparam int T1      = 20;
  localparam int LC      = 2000;
  localparam int LED_CYC = 24 * BC + 1;
  localparam int F       = N * LED_CYC + LC;

  logic clk_i = 1'b0;
  logic rst_i;

  always #5 clk_i = ~clk_i;

  ws281x_chain_drv_if #(.NumLeds(N)) aif ();
  ws281x_chain_drv_if #(.NumLeds(N)) bif ();

  assign bif.wr_en_i   = aif.wr_en_i;
  assign bif.wr_addr_i = aif.wr_addr_i;
  assign bif.wr_data_i = aif.wr_data_i;
  assign bif.go_i      = aif.go_i;
  assign bif.auto_i    = aif.auto_i;

  ws281x_chain_drv #(
    .NumLeds(N), .BitCycles(BC), .T0HCycles(T0), .T1HCycles(T1),
    .LatchCycles(LC), .InvertOut(1)
  ) u_dut_inv (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (aif.slave)
  );

  ws281x_chain_drv #(
    .NumLeds(N), .BitCycles(BC), .T0HCycles(T0), .T1HCycles(T1),
    .LatchCycles(LC), .InvertOut(0)
  ) u_dut_pos (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bif.slave)
  );

  logic [23:0] m_buf [N];
  logic [23:0] snap  [N];
  int          n_pass  = 0;
  int          n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s at %0t: observed %0h expected %0h", tag, $time, obs, exp);
  endtask

  // Line level (true polarity) at position p of a frame; p=0 is LED0's load cycle.
  function automatic logic lvl(input int p);
    int   led;
    int   r;
    int   b;
    int   c;
    logic bv;
    led = p / LED_CYC;
    if (led >= N) return 1'b0;
    r = p % LED_CYC;
    if (r == 0) return 1'b0;
    b  = (r - 1) / BC;
    c  = (r - 1) % BC;
    bv = snap[led][23 - b];
    return (c < (bv ? T1 : T0));
  endfunction

  task automatic chk_cycle(input string tag, input logic lv, input logic busy, input logic done);
    chk({tag, ".dout_inv"}, 32'(aif.dout_o), 32'(lv ^ 1'b1));
    chk({tag, ".dout_pos"}, 32'(bif.dout_o), 32'(lv));
    chk({tag, ".busy"},     32'({aif.busy_o, bif.busy_o}), 32'({busy, busy}));
    chk({tag, ".done"},     32'({aif.done_o, bif.done_o}), 32'({done, done}));
  endtask

  task automatic wr(input int a, input logic [23:0] d);
    aif.wr_en_i   = 1'b1;
    aif.wr_addr_i = 2'(a);
    aif.wr_data_i = d;
    @(negedge clk_i);
    aif.wr_en_i = 1'b0;
    if (a < N) m_buf[a] = d;
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk_i);
    chk_cycle(tag, 1'b0, 1'b0, 1'b0);
  endtask

  // Entered at a negedge whose following posedge starts the frame's LOAD.
  task automatic check_frame(input int go_at, input int wr_at, input int wr_a,
                             input logic [23:0] wr_d, input int auto_off_at,
                             input int stop_at);
    int n;
    n = (stop_at > 0) ? stop_at : F;
    for (int j = 0; j < n; j++) begin
      @(negedge clk_i);
      aif.go_i    = (j == go_at);
      aif.wr_en_i = 1'b0;
      if (j == auto_off_at) aif.auto_i = 1'b0;
      if ((j % LED_CYC == 0) && (j / LED_CYC < N)) snap[j / LED_CYC] = m_buf[j / LED_CYC];
      if (j == wr_at) begin
        aif.wr_en_i   = 1'b1;
        aif.wr_addr_i = 2'(wr_a);
        aif.wr_data_i = wr_d;
        if (wr_a < N) m_buf[wr_a] = wr_d;
      end
      chk_cycle("frame", (j == 0) ? 1'b0 : lvl(j - 1), 1'b1, (j == F - 1));
    end
  endtask

  initial begin
    logic [23:0] rd;
    rst_i         = 1'b1;
    aif.wr_en_i   = 1'b0;
    aif.wr_addr_i = '0;
    aif.wr_data_i = '0;
    aif.go_i      = 1'b0;
    aif.auto_i    = 1'b0;
    for (int i = 0; i < N; i++) m_buf[i] = 24'h0;

    repeat (3) @(negedge clk_i);
    chk_cycle("reset", 1'b0, 1'b0, 1'b0);
    rst_i = 1'b0;
    repeat (20) check_idle("post_reset_quiet");

    // Reference pattern: LED0 green full, LED1 blue LSB, LED2 random.
    wr(0, 24'hFF0000);
    wr(1, 24'h000001);
    wr(2, 24'($urandom));
    aif.go_i = 1'b1;
    check_frame(-1, -1, 0, 24'h0, -1, 0);
    check_idle("after_ref");

    // Out-of-range write is dropped; same-cycle write vs LOAD keeps the old word.
    wr(3, 24'hABCDEF);
    rd = 24'($urandom);
    aif.go_i = 1'b1;
    check_frame(-1, 0, 0, rd, -1, 0);
    check_idle("after_same_cycle_wr");
    aif.go_i = 1'b1;
    check_frame(-1, -1, 0, 24'h0, -1, 0);
    check_idle("after_new_word");

    // go during SEND queues exactly one extra frame.
    aif.go_i = 1'b1;
    check_frame(300, -1, 0, 24'h0, -1, 0);
    check_frame(-1, -1, 0, 24'h0, -1, 0);
    check_idle("after_pending");

    // Write LED1 while LED0 is on the wire; same frame carries it.
    rd = 24'($urandom);
    aif.go_i = 1'b1;
    check_frame(-1, 50, 1, rd, -1, 0);
    check_idle("after_mid_wr");

    // Auto-refresh, dropped mid-way through the second frame.
    aif.auto_i = 1'b1;
    aif.go_i   = 1'b1;
    check_frame(-1, -1, 0, 24'h0, -1, 0);
    check_frame(-1, -1, 0, 24'h0, 100, 0);
    repeat (5) check_idle("after_auto");

    // Fully random contents.
    for (int i = 0; i < N; i++) wr(i, 24'($urandom));
    aif.go_i = 1'b1;
    check_frame(-1, -1, 0, 24'h0, -1, 0);
    check_idle("after_random");

    // Reset while a high pulse is on the line.
    aif.go_i = 1'b1;
    check_frame(-1, -1, 0, 24'h0, -1, 5);
    rst_i = 1'b1;
    for (int i = 0; i < N; i++) m_buf[i] = 24'h0;
    check_idle("mid_frame_reset");
    rst_i = 1'b0;
    repeat (5) check_idle("after_reset_release");
    aif.go_i = 1'b1;
    check_frame(-1, -1, 0, 24'h0, -1, 0);
    check_idle("after_zero_frame");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
